// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/GPU) round-robin arbiter for a single variable-latency memory port.
// One transaction in flight at a time; a stuck memory is aborted after TIMEOUT wait cycles.
//
// state   | meaning
// IDLE    | arbitrate; on a grant latch the winner's request into mem*
// WAIT    | memReq held; wait for memReady or the timeout
// RESP    | one-cycle Ack to the granted requester, then back to IDLE
module mem_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuReq,
  input  logic                  cpuWrite,
  input  logic [DATA_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWdata,
  input  logic [1:0]            cpuLen,
  output logic                  cpuAck,
  output logic                  cpuErr,
  output logic [DATA_WIDTH-1:0] cpuRdata,
  input  logic                  gpuReq,
  input  logic                  gpuWrite,
  input  logic [DATA_WIDTH-1:0] gpuAddr,
  input  logic [DATA_WIDTH-1:0] gpuWdata,
  input  logic [1:0]            gpuLen,
  output logic                  gpuAck,
  output logic                  gpuErr,
  output logic [DATA_WIDTH-1:0] gpuRdata,
  output logic                  memReq,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  output logic [1:0]            memLen,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memReady
);

  // The counter only needs to reach TIMEOUT-1: the abort happens on the edge that would make it TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_len_q, mem_len_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  cpu_err_q, cpu_err_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  gpu_ack_q, gpu_ack_d;
  logic                  gpu_err_q, gpu_err_d;
  logic [DATA_WIDTH-1:0] gpu_rdata_q, gpu_rdata_d;

  logic                  pick_gpu;
  logic                  done;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_len_d    = mem_len_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = cpu_err_q;
    cpu_rdata_d  = cpu_rdata_q;
    gpu_ack_d    = 1'b0;
    gpu_err_d    = gpu_err_q;
    gpu_rdata_d  = gpu_rdata_q;
    // On a tie the GPU wins only if the CPU had the previous grant.
    pick_gpu     = gpuReq & (~cpuReq | ~last_grant_q);
    done         = 1'b0;
    timed_out    = 1'b0;
    rd_val       = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpuReq || gpuReq) begin
          gnt_d       = pick_gpu;
          mem_req_d   = 1'b1;
          mem_write_d = pick_gpu ? gpuWrite : cpuWrite;
          mem_addr_d  = pick_gpu ? gpuAddr  : cpuAddr;
          mem_wdata_d = pick_gpu ? gpuWdata : cpuWdata;
          mem_len_d   = pick_gpu ? gpuLen   : cpuLen;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (memReady) begin
          done   = 1'b1;
          rd_val = memRdata;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (gnt_q) begin
            gpu_ack_d = 1'b1;
            gpu_err_d = timed_out;
            if (!mem_write_q) gpu_rdata_d = rd_val;
          end else begin
            cpu_ack_d = 1'b1;
            cpu_err_d = timed_out;
            if (!mem_write_q) cpu_rdata_d = rd_val;
          end
        end
      end
      ST_RESP: begin
        last_grant_d = gnt_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_len_q    <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      gpu_ack_q    <= 1'b0;
      gpu_err_q    <= 1'b0;
      gpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_len_q    <= mem_len_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      gpu_ack_q    <= gpu_ack_d;
      gpu_err_q    <= gpu_err_d;
      gpu_rdata_q  <= gpu_rdata_d;
    end
  end

  assign memReq   = mem_req_q;
  assign memWrite = mem_write_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memLen   = mem_len_q;
  assign cpuAck   = cpu_ack_q;
  assign cpuErr   = cpu_err_q;
  assign cpuRdata = cpu_rdata_q;
  assign gpuAck   = gpu_ack_q;
  assign gpuErr   = gpu_err_q;
  assign gpuRdata = gpu_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  logic          clk, reset;
  logic          cpuReq, cpuWrite, cpuAck, cpuErr;
  logic [DW-1:0] cpuAddr, cpuWdata, cpuRdata;
  logic [1:0]    cpuLen;
  logic          gpuReq, gpuWrite, gpuAck, gpuErr;
  logic [DW-1:0] gpuAddr, gpuWdata, gpuRdata;
  logic [1:0]    gpuLen;
  logic          memReq, memWrite, memReady;
  logic [DW-1:0] memAddr, memWdata, memRdata;
  logic [1:0]    memLen;

  int n_cmp = 0;
  int n_fail = 0;

  // reference-model state for the random phase
  int            m_last;
  logic [31:0]   m_rd [2];
  logic          pend [2];
  logic          p_wr [2];
  logic [31:0]   p_addr [2];
  logic [31:0]   p_wdata [2];
  logic [1:0]    p_len [2];

  typedef struct {
    int          who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic [31:0] mrd;
    int          lat;
    int          exp_d;
    logic        exp_err;
    logic [31:0] exp_rc;
    logic [31:0] exp_rg;
  } vec_t;

  vec_t tbl [7];

  mem_bus_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuLen(cpuLen),
    .cpuAck(cpuAck), .cpuErr(cpuErr), .cpuRdata(cpuRdata),
    .gpuReq(gpuReq), .gpuWrite(gpuWrite), .gpuAddr(gpuAddr), .gpuWdata(gpuWdata), .gpuLen(gpuLen),
    .gpuAck(gpuAck), .gpuErr(gpuErr), .gpuRdata(gpuRdata),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata), .memLen(memLen),
    .memRdata(memRdata), .memReady(memReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] len);
    if (who == 0) begin
      cpuReq = req; cpuWrite = wr; cpuAddr = addr; cpuWdata = wdata; cpuLen = len;
    end else begin
      gpuReq = req; gpuWrite = wr; gpuAddr = addr; gpuWdata = wdata; gpuLen = len;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_memReq"}, 32'(memReq), 32'd0);
    chk({tag, "_memAddr"}, memAddr, 32'd0);
    chk({tag, "_memWdata"}, memWdata, 32'd0);
    chk({tag, "_ctl"}, 32'({memWrite, memLen, cpuAck, gpuAck, cpuErr, gpuErr}), 32'd0);
    chk({tag, "_cpuRdata"}, cpuRdata, 32'd0);
    chk({tag, "_gpuRdata"}, gpuRdata, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic apply_reset();
    reset = 1'b1;
    cpuReq = 1'b0;
    gpuReq = 1'b0;
    memReady = 1'b0;
    #2;
    check_zero("rst");
    step();
    reset = 1'b0;
  endtask

  // Called with the requests for the next IDLE edge already driven.
  task automatic run_wait(input int win, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] len, input logic [31:0] mrd, input int lat, input int exp_d,
                          input logic exp_err, input logic [31:0] exp_rc, input logic [31:0] exp_rg);
    step();
    chk("grant_memReq", 32'(memReq), 32'd1);
    chk("grant_memAddr", memAddr, addr);
    chk("grant_memWdata", memWdata, wdata);
    chk("grant_memWrLen", 32'({memWrite, memLen}), 32'({wr, len}));
    memRdata = mrd;
    // winner keeps Req high but changes its other inputs; the latched transaction must not move
    drive(win, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)));
    for (int k = 0; k < exp_d; k++) begin
      if (k > 0) begin
        chk("wait_memReq", 32'(memReq), 32'd1);
        chk("wait_memAddr", memAddr, addr);
        chk("wait_memWrLen", 32'({memWrite, memLen}), 32'({wr, len}));
      end
      chk("wait_acks", 32'({cpuAck, gpuAck}), 32'd0);
      memReady = (k == lat);
      step();
    end
    memReady = 1'b0;
    chk("resp_acks", 32'({cpuAck, gpuAck}), (win == 0) ? 32'd2 : 32'd1);
    chk("resp_memReq", 32'(memReq), 32'd0);
    chk("resp_err", 32'((win == 0) ? cpuErr : gpuErr), 32'(exp_err));
    chk("resp_cpuRdata", cpuRdata, exp_rc);
    chk("resp_gpuRdata", gpuRdata, exp_rg);
    if (win == 0) cpuReq = 1'b0;
    else gpuReq = 1'b0;
    step();
    chk("idle_acks", 32'({cpuAck, gpuAck}), 32'd0);
  endtask

  task automatic start_req(input int who);
    pend[who]    = 1'b1;
    p_wr[who]    = 1'($urandom_range(0, 1));
    p_addr[who]  = $urandom;
    p_wdata[who] = $urandom;
    p_len[who]   = 2'($urandom_range(0, 2));
    drive(who, 1'b1, p_wr[who], p_addr[who], p_wdata[who], p_len[who]);
  endtask

  initial begin
    logic [31:0] tie_addr [4];
    int g, w, lat, d;
    logic timed;
    logic [31:0] mrd;

    //         who wr addr          wdata         len    mrd           lat d  err  exp_rc        exp_rg
    tbl[0] = '{0, 1'b0, 32'h100,  32'h0,        LEN_W, 32'hDEADBEEF, 0, 1, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1, 1'b1, 32'h2003, 32'hA5,       LEN_B, 32'h11111111, 3, 4, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{0, 1'b0, 32'h200,  32'h0,        LEN_W, 32'h22222222, 6, 4, 1'b1, 32'h0,        32'h0};
    tbl[3] = '{1, 1'b0, 32'h40,   32'h0,        LEN_H, 32'h12345678, 0, 1, 1'b0, 32'h0,        32'h12345678};
    tbl[4] = '{0, 1'b1, 32'h300,  32'hCAFE0001, LEN_W, 32'h33333333, 2, 3, 1'b0, 32'h0,        32'h12345678};
    tbl[5] = '{1, 1'b0, 32'h44,   32'h0,        LEN_W, 32'h44444444, 4, 4, 1'b1, 32'h0,        32'h0};
    tbl[6] = '{0, 1'b0, 32'h104,  32'h0,        LEN_B, 32'hCAFEF00D, 1, 2, 1'b0, 32'hCAFEF00D, 32'h0};

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    memReady = 1'b0;
    memRdata = 32'h0;
    #1;
    apply_reset();

    // stray memReady with nobody requesting
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    chk("stray_idle_memReq", 32'(memReq), 32'd0);
    step();
    chk("stray_idle_acks", 32'({cpuAck, gpuAck}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].who, 1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].len);
      memReady = 1'b0;
      run_wait(tbl[i].who, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].len, tbl[i].mrd,
               tbl[i].lat, tbl[i].exp_d, tbl[i].exp_err, tbl[i].exp_rc, tbl[i].exp_rg);
    end

    // both requesting continuously from reset: C,G,C,G every 3 edges
    apply_reset();
    tie_addr[0] = 32'hC0; tie_addr[1] = 32'h60; tie_addr[2] = 32'hC0; tie_addr[3] = 32'h60;
    memRdata = 32'h5A5A5A5A;
    memReady = 1'b1;
    drive(0, 1'b1, 1'b0, 32'hC0, 32'h0, LEN_W);
    drive(1, 1'b1, 1'b0, 32'h60, 32'h0, LEN_W);
    g = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (memReq) begin
        if (g < 4) begin
          chk("tie_addr", memAddr, tie_addr[g]);
          chk("tie_gap", 32'(cyc), 32'(3 * g));
        end
        g++;
      end
      if (cyc == 11) begin
        cpuReq = 1'b0;
        gpuReq = 1'b0;
      end
    end
    memReady = 1'b0;
    chk("tie_count", 32'(g), 32'd4);
    chk("tie_cpuRdata", cpuRdata, 32'h5A5A5A5A);
    chk("tie_gpuRdata", gpuRdata, 32'h5A5A5A5A);

    // reset in the middle of WAIT
    drive(0, 1'b1, 1'b0, 32'h500, 32'h0, LEN_W);
    step();
    chk("midrst_grant", 32'(memReq), 32'd1);
    step();
    chk("midrst_wait", 32'(memReq), 32'd1);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_ack", 32'({cpuAck, gpuAck, memReq}), 32'd0);
      step();
    end
    drive(0, 1'b1, 1'b0, 32'h504, 32'h0, LEN_W);
    run_wait(0, 1'b0, 32'h504, 32'h0, LEN_W, 32'h0BADF00D, 1, 2, 1'b0, 32'h0BADF00D, 32'h0);

    // memReady high on the IDLE edge that samples a GPU read must not complete it
    drive(1, 1'b1, 1'b0, 32'h80, 32'h0, LEN_H);
    memReady = 1'b1;
    run_wait(1, 1'b0, 32'h80, 32'h0, LEN_H, 32'h77777777, 2, 3, 1'b0, 32'h0BADF00D, 32'h77777777);

    // randomized transactions against the reference model
    apply_reset();
    m_last = 1;
    m_rd[0] = 32'h0; m_rd[1] = 32'h0;
    pend[0] = 1'b0;  pend[1] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      for (int who = 0; who < 2; who++)
        if (!pend[who] && $urandom_range(0, 1) == 1) start_req(who);
      if (!pend[0] && !pend[1]) start_req(int'($urandom_range(0, 1)));
      memReady = 1'($urandom_range(0, 1));
      w     = (pend[0] && pend[1]) ? (1 - m_last) : (pend[1] ? 1 : 0);
      lat   = int'($urandom_range(0, 6));
      mrd   = $urandom;
      timed = (lat >= TO);
      d     = timed ? TO : lat + 1;
      if (!p_wr[w]) m_rd[w] = timed ? 32'h0 : mrd;
      m_last = w;
      run_wait(w, p_wr[w], p_addr[w], p_wdata[w], p_len[w], mrd, lat, d, timed, m_rd[0], m_rd[1]);
      pend[w] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the single memory port between the CPU control unit's load/store/fetch path and the GPU-side requester. It serializes one transaction at a time onto a variable-latency memory port with a ready handshake. Ties are resolved round-robin, and a stuck memory is reported through a per-transaction timeout. It sits between the core datapath's memory address/data muxing and the memory/bus interface.

## Interface

- DATA_WIDTH, 32, width of address, write data and read data
- TIMEOUT, 255, maximum WAIT cycles before a transaction is aborted; 0 disables the timeout
- clk  in  1  clock; all registers update on its rising edge
- reset  in  1  asynchronous, active-high reset
- cpuReq  in  1  CPU transaction request; held high until cpuAck is seen
- cpuWrite  in  1  1 = store, 0 = load/fetch
- cpuAddr  in  DATA_WIDTH  byte address
- cpuWdata  in  DATA_WIDTH  store data
- cpuLen  in  2  access length, `LOAD_STORE_BYTE/HALF/WORD` encodings from riscvdefs.vh
- cpuAck  out  1  one-cycle completion pulse
- cpuErr  out  1  valid with cpuAck; 1 = timed out
- cpuRdata  out  DATA_WIDTH  load data; valid from cpuAck, held until the next CPU read completes
- gpuReq, gpuWrite, gpuAddr, gpuWdata, gpuLen, gpuAck, gpuErr, gpuRdata  same as the cpu* ports, for the GPU requester
- memReq  out  1  memory request; held until memReady is sampled
- memWrite  out  1  write strobe qualifier
- memAddr  out  DATA_WIDTH  latched address
- memWdata  out  DATA_WIDTH  latched write data
- memLen  out  2  latched length
- memRdata  in  DATA_WIDTH  read data, valid when memReady=1
- memReady  in  1  transaction complete; sampled only in WAIT

## Operation

- The FSM has three states: IDLE, WAIT and RESP. A `lastGrant` bit holds 0 for CPU and 1 for GPU.
- IDLE:
  - Only cpuReq: grant CPU.
  - Only gpuReq: grant GPU.
  - Both: grant the requester that is not `lastGrant`.
  - On a grant, latch the winner's addr, wdata, len and write into the mem* registers, set memReq=1, clear the timeout counter, and go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - memReq=1 and the mem* outputs stay stable.
  - memReady=1 at an edge:
    - memReq goes to 0 and the state moves to RESP.
    - If the transaction was a read, memRdata is captured into the granted requester's Rdata register.
    - Err goes to 0.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT:
    - memReq goes to 0 and the state moves to RESP.
    - Err goes to 1.
    - A read loads Rdata with 0.
- RESP:
  - The granted requester's Ack=1 for exactly one cycle and `lastGrant` is updated to that requester.
  - The next state is always IDLE.
- The non-granted requester's Ack, Err and Rdata never change.
- A write completion leaves Rdata unchanged.
- memReady seen in IDLE or RESP is ignored.
- Requester inputs are sampled only in IDLE. Changes during WAIT or RESP have no effect on the transaction in flight.

## Timing

- Reset (asynchronous, immediate):
  - state=IDLE and lastGrant=1, so the CPU wins the first tie.
  - The counter is 0.
  - All outputs are 0: memReq, memWrite, memAddr, memWdata, memLen, both Ack, both Err and both Rdata.
- Reset mid-transaction drops memReq immediately, emits no Ack, and discards the transaction.
- Latency with memReady high in the first WAIT cycle:
  - Request sampled at edge 0 (IDLE→WAIT, memReq=1).
  - memReady sampled at edge 1 (→RESP).
  - Ack is high between edges 1 and 2.
- Each memory wait state adds one cycle.
- A timeout produces Ack TIMEOUT+1 cycles after the grant edge.
- Back-to-back transactions: after RESP there is always one IDLE cycle, so the next grant is at the earliest 3 edges after the previous grant. A requester that registers Ack drops Req in time, so no duplicate grant occurs.
- Round-robin fairness: with both requesters continuously requesting, grants strictly alternate.

## Test plan

- CPU read, zero wait, memRdata=0xDEADBEEF, cpuAddr=0x100, WORD:
  - memReq high for 1 cycle with memAddr=0x100.
  - cpuAck pulses 2 cycles after the request is sampled, with cpuRdata=0xDEADBEEF and cpuErr=0.
  - gpuAck stays 0.
- GPU byte write, addr=0x2003, wdata=0xA5, memReady after 3 wait cycles:
  - memWrite=1 and memLen=`LOAD_STORE_BYTE`, stable for 4 cycles.
  - gpuAck follows 1 cycle after memReady is sampled.
  - gpuRdata is unchanged.
- cpuReq and gpuReq both asserted after reset and re-asserted continuously:
  - Grant order is CPU, GPU, CPU, GPU.
  - Each grant is separated by exactly 3 cycles with zero-wait memory.
- TIMEOUT=4, memReady held 0, CPU read:
  - memReq is high for 4 cycles and then drops.
  - cpuAck=1 with cpuErr=1 and cpuRdata=0.
  - A following zero-wait GPU read completes normally.
- Reset asserted between edges during WAIT:
  - memReq and all outputs go to 0 before the next clock edge.
  - After release, a new CPU read completes normally, and no stale Ack appears.
- memReady pulsed while in IDLE, then a GPU read issued:
  - The stray pulse is ignored.
  - The GPU read waits for a fresh memReady in WAIT.
